// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game-step controller.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_STEP,
        S_EVAL,
        S_GROW,
        S_SPAWN_REQ,
        S_SPAWN_CHK,
        S_OVER
    } state_t;

    localparam int CELL_SIZE  = 25;
    localparam int PF_WIDTH   = 602;
    localparam int PF_HEIGHT  = 477;
    localparam int FRUIT_INIT = 152;

    // Same axis, opposite sense: the snake would run into its own neck.
    function automatic logic is_reversal(input dir_t req, input dir_t cur);
        return (req[1] == cur[1]) && (req[0] != cur[0]);
    endfunction

endpackage

// File: rtl/snake_step_sequencer_bcd.sv
// Four-digit BCD score counter: increment with ripple carry, 9999 wraps to 0000.
module bcd_counter4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] count
);

    logic [15:0] count_q, count_d;
    logic [3:0]  carry;

    always_comb begin
        count_d  = count_q;
        carry    = 4'b0;
        carry[0] = en;
        for (int i = 1; i < 4; i++) begin
            carry[i] = carry[i-1] && (count_q[(i-1)*4 +: 4] == 4'd9);
        end
        for (int i = 0; i < 4; i++) begin
            if (carry[i]) begin
                if (count_q[i*4 +: 4] == 4'd9) begin
                    count_d[i*4 +: 4] = 4'd0;
                end else begin
                    count_d[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
                end
            end
        end
        if (clr) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/snake_step_sequencer.sv
// Snake game-step controller: step tick, move/eval/grow sequencing,
// BCD score and fruit respawn handshake.
module snake_step_sequencer
    import snake_pkg::*;
#(
    parameter int TICK_CYCLES   = 8000000,
    parameter int MAX_SEGMENTS  = 20,
    parameter int RESPAWN_TRIES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic [1:0]  dir_req,
    input  logic        dir_req_valid,
    input  logic        hit_body,
    input  logic        hit_fruit,
    input  logic        cand_on_body,
    input  logic [9:0]  rand_x,
    input  logic [9:0]  rand_y,
    input  logic        fruit_ack,
    output logic        fruit_req,
    output logic [9:0]  fruit_x,
    output logic [9:0]  fruit_y,
    output logic        fruit_load,
    output logic        move_stb,
    output logic        grow_stb,
    output logic        clear_stb,
    output logic [1:0]  dir_out,
    output logic [4:0]  length,
    output logic [15:0] score,
    output logic        running,
    output logic        game_over
);

    localparam int CNT_W = $clog2(TICK_CYCLES + 1);
    localparam int TRY_W = $clog2(RESPAWN_TRIES + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_t             dir_q, dir_d;
    dir_t             pend_q, pend_d;
    logic [4:0]       len_q, len_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [9:0]       fx_q, fx_d;
    logic [9:0]       fy_q, fy_d;
    logic             load_q, load_d;
    logic             clear_q, clear_d;
    logic             score_clr;
    logic             score_en;
    logic             dir_ok;

    assign dir_ok = dir_req_valid && !is_reversal(dir_t'(dir_req), dir_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        pend_d    = dir_ok ? dir_t'(dir_req) : pend_q;
        len_d     = len_q;
        tries_d   = tries_q;
        fx_d      = fx_q;
        fy_d      = fy_q;
        load_d    = 1'b0;
        clear_d   = 1'b0;
        score_clr = 1'b0;
        score_en  = 1'b0;
        move_stb  = 1'b0;
        grow_stb  = 1'b0;
        fruit_req = 1'b0;
        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d   = S_WAIT;
                    cnt_d     = '0;
                    dir_d     = DIR_RIGHT;
                    pend_d    = DIR_RIGHT;
                    len_d     = '0;
                    score_clr = 1'b1;
                    clear_d   = 1'b1;
                end
            end
            S_WAIT: begin
                if (!pause) begin
                    if (cnt_q == CNT_W'(TICK_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_STEP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_STEP: begin
                move_stb = 1'b1;
                dir_d    = pend_q;
                state_d  = S_EVAL;
            end
            S_EVAL: begin
                if (hit_body) begin
                    state_d = S_OVER;
                end else if (hit_fruit) begin
                    state_d = S_GROW;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_GROW: begin
                score_en = 1'b1;
                if (len_q < 5'(MAX_SEGMENTS)) begin
                    grow_stb = 1'b1;
                    len_d    = len_q + 5'd1;
                end
                tries_d = '0;
                state_d = S_SPAWN_REQ;
            end
            S_SPAWN_REQ: begin
                fruit_req = 1'b1;
                if (fruit_ack) begin
                    fx_d    = rand_x;
                    fy_d    = rand_y;
                    state_d = S_SPAWN_CHK;
                end
            end
            S_SPAWN_CHK: begin
                if (cand_on_body && tries_q < TRY_W'(RESPAWN_TRIES - 1)) begin
                    tries_d = tries_q + 1'b1;
                    state_d = S_SPAWN_REQ;
                end else begin
                    load_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            len_q   <= '0;
            tries_q <= '0;
            fx_q    <= 10'(FRUIT_INIT);
            fy_q    <= 10'(FRUIT_INIT);
            load_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            len_q   <= len_d;
            tries_q <= tries_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            load_q  <= load_d;
            clear_q <= clear_d;
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (score_clr),
        .en    (score_en),
        .count (score)
    );

    // The datapath moves during move_stb, so show it the direction being applied.
    assign dir_out    = (state_q == S_STEP) ? pend_q : dir_q;
    assign fruit_x    = fx_q;
    assign fruit_y    = fy_q;
    assign fruit_load = load_q;
    assign clear_stb  = clear_q;
    assign length     = len_q;
    assign running    = (state_q != S_IDLE) && (state_q != S_OVER);
    assign game_over  = (state_q == S_OVER);

endmodule

// File: tb/tb_snake_step_sequencer.sv
// Bench for snake_step_sequencer: per-cycle behavioural model plus directed checks.
module tb_snake_step_sequencer;

    localparam int TICK = 10;
    localparam int MAXS = 20;
    localparam int TRIES = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, pause, dir_req_valid;
    logic [1:0]  dir_req;
    logic        hit_body, hit_fruit, cand_on_body, fruit_ack;
    logic [9:0]  rand_x, rand_y;
    logic        fruit_req, fruit_load, move_stb, grow_stb, clear_stb;
    logic [9:0]  fruit_x, fruit_y;
    logic [1:0]  dir_out;
    logic [4:0]  length;
    logic [15:0] score;
    logic        running, game_over;

    logic        b_clr, b_en;
    logic [15:0] b_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ack_idx = 0;
    int grow_cnt = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    snake_step_sequencer #(
        .TICK_CYCLES   (TICK),
        .MAX_SEGMENTS  (MAXS),
        .RESPAWN_TRIES (TRIES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .pause         (pause),
        .dir_req       (dir_req),
        .dir_req_valid (dir_req_valid),
        .hit_body      (hit_body),
        .hit_fruit     (hit_fruit),
        .cand_on_body  (cand_on_body),
        .rand_x        (rand_x),
        .rand_y        (rand_y),
        .fruit_ack     (fruit_ack),
        .fruit_req     (fruit_req),
        .fruit_x       (fruit_x),
        .fruit_y       (fruit_y),
        .fruit_load    (fruit_load),
        .move_stb      (move_stb),
        .grow_stb      (grow_stb),
        .clear_stb     (clear_stb),
        .dir_out       (dir_out),
        .length        (length),
        .score         (score),
        .running       (running),
        .game_over     (game_over)
    );

    bcd_counter4 u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (b_clr),
        .en    (b_en),
        .count (b_count)
    );

    function automatic logic [9:0] rx(input int i);
        return 10'((i * 7 + 3) % 600);
    endfunction

    function automatic logic [9:0] ry(input int i);
        return 10'((i * 11 + 5) % 470);
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Random-coordinate source: acknowledges a request in the cycle it is seen.
    initial begin
        fruit_ack = 1'b0;
        rand_x = '0;
        rand_y = '0;
        forever begin
            @(negedge clk);
            if (fruit_req && !fruit_ack) begin
                fruit_ack = 1'b1;
                rand_x = rx(ack_idx);
                rand_y = ry(ack_idx);
                ack_idx++;
            end else begin
                fruit_ack = 1'b0;
            end
        end
    end

    always @(negedge clk) if (grow_stb === 1'b1) grow_cnt <= grow_cnt + 1;

    // Behavioural model: phase plus remaining wait ticks, decimal score.
    localparam int P_IDLE = 0, P_WAIT = 1, P_STEP = 2, P_EVAL = 3;
    localparam int P_GROW = 4, P_REQ = 5, P_CHK = 6, P_OVER = 7;

    int         m_ph, m_left, m_score, m_len, m_tries;
    logic [1:0] m_dir, m_pend;
    logic [9:0] m_fx, m_fy;
    logic       m_load, m_clear;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph <= P_IDLE; m_left <= 0; m_score <= 0; m_len <= 0;
            m_tries <= 0; m_dir <= 2'd3; m_pend <= 2'd3;
            m_fx <= 10'd152; m_fy <= 10'd152; m_load <= 1'b0; m_clear <= 1'b0;
        end else begin
            m_load <= 1'b0;
            m_clear <= 1'b0;
            if (dir_req_valid && !(dir_req[1] == m_dir[1] && dir_req[0] != m_dir[0]))
                m_pend <= dir_req;
            case (m_ph)
                P_IDLE, P_OVER: if (start) begin
                    m_ph <= P_WAIT; m_left <= TICK; m_score <= 0; m_len <= 0;
                    m_dir <= 2'd3; m_pend <= 2'd3; m_clear <= 1'b1;
                end
                P_WAIT: if (!pause) begin
                    if (m_left == 1) m_ph <= P_STEP;
                    else m_left <= m_left - 1;
                end
                P_STEP: begin m_dir <= m_pend; m_ph <= P_EVAL; end
                P_EVAL: begin
                    if (hit_body) m_ph <= P_OVER;
                    else if (hit_fruit) m_ph <= P_GROW;
                    else begin m_ph <= P_WAIT; m_left <= TICK; end
                end
                P_GROW: begin
                    m_score <= (m_score + 1) % 10000;
                    if (m_len < MAXS) m_len <= m_len + 1;
                    m_tries <= 0;
                    m_ph <= P_REQ;
                end
                P_REQ: if (fruit_ack) begin
                    m_fx <= rand_x; m_fy <= rand_y; m_ph <= P_CHK;
                end
                P_CHK: begin
                    if (cand_on_body && m_tries < TRIES - 1) begin
                        m_tries <= m_tries + 1; m_ph <= P_REQ;
                    end else begin
                        m_load <= 1'b1; m_ph <= P_WAIT; m_left <= TICK;
                    end
                end
                default: m_ph <= P_IDLE;
            endcase
        end
    end

    logic [49:0] exp_v, act_v;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_v = {m_ph == P_REQ, m_fx, m_fy, m_load, m_ph == P_STEP,
                     (m_ph == P_GROW) && (m_len < MAXS), m_clear,
                     (m_ph == P_STEP) ? m_pend : m_dir, 5'(m_len),
                     to_bcd(m_score), m_ph != P_IDLE && m_ph != P_OVER,
                     m_ph == P_OVER};
            act_v = {fruit_req, fruit_x, fruit_y, fruit_load, move_stb,
                     grow_stb, clear_stb, dir_out, length, score,
                     running, game_over};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL cycle_model @%0d: got %h expected %h", cyc, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // sel: 0 move_stb, 1 game_over, 2 fruit_load, 3 fruit_req
    task automatic wait_for(input int sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            case (sel)
                0: ok = (move_stb === 1'b1);
                1: ok = (game_over === 1'b1);
                2: ok = (fruit_load === 1'b1);
                default: ok = (fruit_req === 1'b1);
            endcase
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_timeout: event %0d not seen within %0d cycles", sel, budget);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        bit ok;
        int t0, m1, base, g0;
        rst_n = 1'b0; start = 1'b0; pause = 1'b0;
        dir_req = 2'd0; dir_req_valid = 1'b0;
        hit_body = 1'b0; hit_fruit = 1'b0; cand_on_body = 1'b0;
        b_clr = 1'b0; b_en = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("rst_fruit_x", 32'(fruit_x), 152);
        chk("rst_fruit_y", 32'(fruit_y), 152);
        chk("rst_dir", 32'(dir_out), 3);
        chk("rst_status", {score, length, running, game_over, fruit_req}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        t0 = cyc;
        pulse_start();
        wait_for(0, 40, ok);
        if (ok) chk("first_move_delay", 32'(cyc - t0), 11);
        chk("first_dir", 32'(dir_out), 3);

        repeat (2) @(negedge clk);
        dir_req = 2'd2; dir_req_valid = 1'b1;
        @(negedge clk);
        dir_req_valid = 1'b0;
        wait_for(0, 40, ok);
        chk("reverse_rejected", 32'(dir_out), 3);

        repeat (2) @(negedge clk);
        dir_req = 2'd0; dir_req_valid = 1'b1;
        @(negedge clk);
        dir_req = 2'd1;
        @(negedge clk);
        dir_req_valid = 1'b0;
        wait_for(0, 40, ok);
        chk("last_request_wins", 32'(dir_out), 1);

        hit_body = 1'b1; hit_fruit = 1'b1;
        wait_for(1, 10, ok);
        chk("both_hits_over", {game_over, running}, 2'b10);
        chk("both_hits_score", 32'(score), 0);
        hit_body = 1'b0; hit_fruit = 1'b0;
        repeat (3) @(negedge clk);

        g0 = grow_cnt;
        pulse_start();
        hit_fruit = 1'b1;
        for (int i = 0; i < 999; i++) begin
            wait_for(2, 40, ok);
            if (!ok) break;
        end
        chk("score_0999", 32'(score), 32'h0999);
        chk("length_cap", 32'(length), MAXS);
        chk("grow_pulses", 32'(grow_cnt - g0), MAXS);
        wait_for(2, 40, ok);
        hit_fruit = 1'b0;
        chk("score_carry_1000", 32'(score), 32'h1000);
        chk("length_still_cap", 32'(length), MAXS);

        repeat (2) @(negedge clk);
        base = ack_idx;
        cand_on_body = 1'b1; hit_fruit = 1'b1;
        wait_for(3, 40, ok);
        hit_fruit = 1'b0;
        wait_for(2, 200, ok);
        cand_on_body = 1'b0;
        chk("respawn_handshakes", 32'(ack_idx - base), TRIES);
        chk("respawn_x", 32'(fruit_x), 32'(rx(base + TRIES - 1)));
        chk("respawn_y", 32'(fruit_y), 32'(ry(base + TRIES - 1)));

        wait_for(0, 40, ok);
        m1 = cyc;
        repeat (2) @(negedge clk);
        pulse_start();
        @(negedge clk);
        pause = 1'b1;
        repeat (50) @(negedge clk);
        pause = 1'b0;
        wait_for(0, 100, ok);
        if (ok) chk("pause_delay", 32'(cyc - m1), TICK + 2 + 50);
        chk("start_ignored_running", 32'(running), 1);

        @(negedge clk);
        b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
        chk("bcd_clear", 32'(b_count), 0);
        b_en = 1'b1;
        repeat (9999) @(negedge clk);
        chk("bcd_9999", 32'(b_count), 32'h9999);
        @(negedge clk);
        b_en = 1'b0;
        chk("bcd_wrap", 32'(b_count), 0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
